spectrum_frame_renderer: RTL and testbench
==========================================

// Module: spectrum_frame_renderer
// PURPOSE
//  Parametrised spectrum bar renderer: takes NBINS FFT magnitudes and latches them
//  only while VGA is outside active video, compresses each bin to a log2 level, and
//  keeps a per-bin peak-hold with frame-based decay. Outputs per-pixel RGB for bars
//  and peak markers in one of four display modes. Sits between FFT core and VGA out.
// PARAMETERS
//  NBINS    16   number of spectrum bins / bars
//  DW       16   width of each input magnitude
//  LW       4    log2 level width; max level = 2**LW-1
//  BAR_W    32   pixel pitch per bar; last 2 columns of each pitch are gap
//  STEP_H   24   bar pixels per level
//  X0       64   left x of bar 0;  Y_BASE 440  bottom row of bars (inclusive)
//  DECAY_FR 4    frame_start pulses between peak decrements
// PORTS
//  i_clk         in   1          pixel/system clock
//  i_rst_n       in   1          asynchronous reset, active low
//  i_fft_data    in   NBINS*DW   bin k at [k*DW +: DW]
//  i_fft_done    in   1          1-cycle pulse: i_fft_data valid this cycle or later
//  i_vga_lock    in   1          1 = active video (latching forbidden)
//  i_frame_start in   1          1-cycle pulse at start of each frame
//  i_vga_x       in   11         current pixel x;  i_vga_y in 11 current pixel y
//  i_mode        in   2          0 solid bars, 1 gradient, 2 bars+peak, 3 blank
//  o_vga_r/g/b   out  8 each     pixel colour, registered
//  o_frame_cnt   out  16         number of frames latched, wraps at 2**16
// BEHAVIOUR
//  Reset (i_rst_n=0, async, any time): state=S_IDLE, all levels/peaks=0, decay
//   counter=0, o_vga_r/g/b=0, o_frame_cnt=0. Effective immediately, mid-frame included.
//  FSM: S_IDLE --i_fft_done--> S_PEND. S_PEND --!i_vga_lock--> S_IDLE, same edge:
//   level[k] <= log2(i_fft_data[k]) sampled that cycle, peak update, o_frame_cnt+1.
//   i_fft_done while in S_PEND: ignored (stay S_PEND; newest data taken at latch).
//   i_fft_done with !i_vga_lock in S_IDLE: enters S_PEND, latches next cycle earliest.
//  log2: x==0 -> 0; else index of MSB of x, saturated to 2**LW-1.
//  Peak: on latch, peak[k] <= max(peak[k], new level[k]). Decay counter counts
//   i_frame_start; on reaching DECAY_FR it clears and every peak[k] > level[k]
//   decrements by 1. Latch and decay same cycle: latch max applied, decay skipped.
//  Pixel pipeline, latency 2 cycles (x/y at edge n -> RGB valid after edge n+2):
//   stage1: k=(x-X0)/BAR_W, col=(x-X0)%BAR_W, inbar = x>=X0, k<NBINS,
//     col<BAR_W-2; dy=Y_BASE-y (y<=Y_BASE else outside);
//     bar_hit = inbar & dy < level[k]*STEP_H; pk_hit = inbar & peak[k]!=0 &
//     dy == peak[k]*STEP_H.
//   stage2 colour: mode0 bar -> (0,255,0); mode1 bar -> (level*16,255-level*16,64)
//     (LW=4 scaling; other LW scale to 8 bits by left shift); mode2 pk_hit ->
//     (255,255,255) takes priority, bar as mode0; mode3 -> 0; otherwise (0,0,0).
//  Level/peak arrays update only outside active video, so a frame never tears.
//  i_mode sampled in stage1, takes effect with that pixel.
// TESTING
//  1 Reset, i_mode=0, sweep x/y -> all RGB 0; o_frame_cnt=0.
//  2 Bin0=16'h8000, others 0, done pulse with lock=1 for 10 cycles then lock=0 ->
//    latch exactly one cycle after lock falls; level0=15; pixel (64,440) green,
//    (64,440-360)=y80 black, (94,440) gap black; o_frame_cnt=1.
//  3 Two done pulses during one lock period, data changed between -> single latch,
//    second data used, o_frame_cnt increments by 1.
//  4 Mode2: latch level 8 then level 2 on bin3 -> peak=8 marker white at y=248;
//    after 4 frame_start pulses peak=7 (y=272); decays stop at 2.
//  5 Check latency: step x into bar region -> RGB changes exactly 2 clocks later;
//    bin value 1 -> level 0 -> no bar; 16'hFFFF -> level 15.
//  6 Assert i_rst_n=0 during S_PEND mid-frame -> outputs 0 at once, no latch after.

Source files
------------

// File: rtl/spectrum_frame_renderer_if.sv
// Bundle of the FFT-side and VGA-side signals of the spectrum renderer.
// The master drives the FFT results and the VGA timing. The slave is the renderer itself.
interface spectrum_frame_renderer_if #(
  parameter int NBINS = 16,
  parameter int DW    = 16
);
  logic [NBINS*DW-1:0] i_fft_data;
  logic                i_fft_done;
  logic                i_vga_lock;
  logic                i_frame_start;
  logic [10:0]         i_vga_x;
  logic [10:0]         i_vga_y;
  logic [1:0]          i_mode;
  logic [7:0]          o_vga_r;
  logic [7:0]          o_vga_g;
  logic [7:0]          o_vga_b;
  logic [15:0]         o_frame_cnt;

  modport master (
    output i_fft_data, i_fft_done, i_vga_lock, i_frame_start, i_vga_x, i_vga_y, i_mode,
    input  o_vga_r, o_vga_g, o_vga_b, o_frame_cnt
  );

  modport slave (
    input  i_fft_data, i_fft_done, i_vga_lock, i_frame_start, i_vga_x, i_vga_y, i_mode,
    output o_vga_r, o_vga_g, o_vga_b, o_frame_cnt
  );
endinterface

// File: rtl/spectrum_frame_renderer.sv
// Spectrum bar renderer.
// FFT magnitudes are latched only outside active video and compressed to log2 levels.
// Each bin keeps a peak-hold value that decays once every DECAY_FR frames.
// A two-stage pixel pipeline turns (x, y) into bar and peak-marker colours.
module spectrum_frame_renderer #(
  parameter int NBINS    = 16,
  parameter int DW       = 16,
  parameter int LW       = 4,
  parameter int BAR_W    = 32,
  parameter int STEP_H   = 24,
  parameter int X0       = 64,
  parameter int Y_BASE   = 440,
  parameter int DECAY_FR = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  spectrum_frame_renderer_if.slave  bus
);

  localparam int DCW = (DECAY_FR > 1) ? $clog2(DECAY_FR) : 1;
  localparam logic [LW-1:0] LMAX = '1;

  typedef enum logic [0:0] {S_IDLE, S_PEND} state_e;

  state_e          state_q;
  logic [15:0]     frameCnt_q;
  logic [DCW-1:0]  decayCnt_q;
  logic [LW-1:0]   level_q [NBINS];
  logic [LW-1:0]   peak_q  [NBINS];
  logic [LW-1:0]   level_d [NBINS];
  logic [LW-1:0]   peak_d  [NBINS];

  logic            doLatch;
  logic            decayTick;

  logic [31:0]     pixX, pixY, dx, binIdx, binCol, dy, barTop, peakRow;
  logic            inBar, inRows;
  logic [LW-1:0]   binLevel, binPeak;
  logic            barHit_d, pkHit_d;

  logic            barHit_q, pkHit_q;
  logic [LW-1:0]   pixLevel_q;
  logic [1:0]      pixMode_q;

  logic [7:0]      shade;
  logic [7:0]      red_d, green_d, blue_d;
  logic [7:0]      red_q, green_q, blue_q;

  // Index of the most significant set bit, clipped to the largest level
  function automatic logic [LW-1:0] levelOf(input logic [DW-1:0] v);
    int msb;
    msb = 0;
    for (int i = 0; i < DW; i++) begin
      if (v[i]) msb = i;
    end
    if (msb > int'(LMAX)) msb = int'(LMAX);
    return LW'(msb);
  endfunction

  // Latch fires when a pending result meets blanking; decay fires on the DECAY_FR-th frame pulse
  always_comb begin
    doLatch   = (state_q == S_PEND) && !bus.i_vga_lock;
    decayTick = bus.i_frame_start && (decayCnt_q == DCW'(DECAY_FR - 1));
  end

  // Pending-latch FSM; the frame counter advances on every latch
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      frameCnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.i_fft_done) state_q <= S_PEND;
        S_PEND: begin
          if (!bus.i_vga_lock) begin
            state_q    <= S_IDLE;
            frameCnt_q <= frameCnt_q + 16'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Frame pulse counter that sets the peak decay rate
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      decayCnt_q <= '0;
    end else if (bus.i_frame_start) begin
      decayCnt_q <= decayTick ? '0 : decayCnt_q + DCW'(1);
    end
  end

  // Next levels and peaks; a latch takes precedence over a decay in the same cycle
  always_comb begin
    for (int k = 0; k < NBINS; k++) begin
      level_d[k] = level_q[k];
      peak_d[k]  = peak_q[k];
      if (doLatch) begin
        level_d[k] = levelOf(bus.i_fft_data[k*DW +: DW]);
        peak_d[k]  = (level_d[k] > peak_q[k]) ? level_d[k] : peak_q[k];
      end else if (decayTick && (peak_q[k] > level_q[k])) begin
        peak_d[k]  = peak_q[k] - LW'(1);
      end
    end
  end

  // Level and peak storage
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NBINS; k++) begin
        level_q[k] <= '0;
        peak_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NBINS; k++) begin
        level_q[k] <= level_d[k];
        peak_q[k]  <= peak_d[k];
      end
    end
  end

  // Pixel stage 1 logic: locate the bar under (x, y) and test the bar and marker rows
  always_comb begin
    pixX     = 32'(bus.i_vga_x);
    pixY     = 32'(bus.i_vga_y);
    dx       = (pixX >= 32'(X0)) ? pixX - 32'(X0) : '0;
    binIdx   = dx / 32'(BAR_W);
    binCol   = dx % 32'(BAR_W);
    inBar    = (pixX >= 32'(X0)) && (binIdx < 32'(NBINS)) && (binCol < 32'(BAR_W - 2));
    inRows   = (pixY <= 32'(Y_BASE));
    dy       = 32'(Y_BASE) - pixY;
    binLevel = '0;
    binPeak  = '0;
    for (int k = 0; k < NBINS; k++) begin
      if (binIdx == 32'(k)) begin
        binLevel = level_q[k];
        binPeak  = peak_q[k];
      end
    end
    barTop   = 32'(binLevel) * 32'(STEP_H);
    peakRow  = 32'(binPeak) * 32'(STEP_H);
    barHit_d = inBar && inRows && (dy < barTop);
    pkHit_d  = inBar && inRows && (binPeak != '0) && (dy == peakRow);
  end

  // Pixel stage 1 registers; the display mode travels with its pixel
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      barHit_q   <= 1'b0;
      pkHit_q    <= 1'b0;
      pixLevel_q <= '0;
      pixMode_q  <= '0;
    end else begin
      barHit_q   <= barHit_d;
      pkHit_q    <= pkHit_d;
      pixLevel_q <= binLevel;
      pixMode_q  <= bus.i_mode;
    end
  end

  // Pixel stage 2 logic: choose the colour from the mode and the hit flags
  always_comb begin
    shade   = 8'(32'(pixLevel_q) << (8 - LW));
    red_d   = 8'd0;
    green_d = 8'd0;
    blue_d  = 8'd0;
    case (pixMode_q)
      2'd0: if (barHit_q) green_d = 8'd255;
      2'd1: begin
        if (barHit_q) begin
          red_d   = shade;
          green_d = 8'd255 - shade;
          blue_d  = 8'd64;
        end
      end
      2'd2: begin
        if (pkHit_q) begin
          red_d   = 8'd255;
          green_d = 8'd255;
          blue_d  = 8'd255;
        end else if (barHit_q) begin
          green_d = 8'd255;
        end
      end
      default: ;
    endcase
  end

  // Pixel stage 2 registers driving the VGA colour outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else begin
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
    end
  end

  assign bus.o_vga_r     = red_q;
  assign bus.o_vga_g     = green_q;
  assign bus.o_vga_b     = blue_q;
  assign bus.o_frame_cnt = frameCnt_q;

endmodule

// File: tb/tb_spectrum_frame_renderer.sv
// Testbench for the spectrum frame renderer.
// Directed scenarios and a randomized phase are checked against a frame-level reference model.
module tb_spectrum_frame_renderer;

  localparam int NBINS    = 16;
  localparam int DW       = 16;
  localparam int LMAX     = 15;
  localparam int BAR_W    = 32;
  localparam int STEP_H   = 24;
  localparam int X0       = 64;
  localparam int Y_BASE   = 440;
  localparam int DECAY_FR = 4;

  localparam logic [31:0] BLACK = 32'h000000;
  localparam logic [31:0] GREEN = 32'h00FF00;
  localparam logic [31:0] WHITE = 32'hFFFFFF;

  logic clk;
  logic rst_n;

  int checkCount;
  int errorCount;

  // Reference model state: per-bin level and peak, frame pulses seen, latched frames, pending flag
  int mLevel [NBINS];
  int mPeak  [NBINS];
  int mPulses;
  int mFrames;
  bit mPend;

  spectrum_frame_renderer_if #(.NBINS(NBINS), .DW(DW)) bus ();

  spectrum_frame_renderer dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // Free-running 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Count a comparison and report it if the values differ
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] rgbNow();
    return {8'h00, bus.o_vga_r, bus.o_vga_g, bus.o_vga_b};
  endfunction

  // Floor of log2, with 0 mapped to 0 and the result clipped to the largest level
  function automatic int refLevel(input int v);
    int r;
    if (v == 0) return 0;
    r = $clog2(v + 1) - 1;
    return (r > LMAX) ? LMAX : r;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < NBINS; k++) begin
      mLevel[k] = 0;
      mPeak[k]  = 0;
    end
    mPulses = 0;
    mFrames = 0;
    mPend   = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven
  task automatic modelStep();
    bit latch;
    bit decayNow;
    int lvl;
    latch    = mPend && !bus.i_vga_lock;
    decayNow = 1'b0;
    if (bus.i_frame_start) begin
      mPulses++;
      if (mPulses == DECAY_FR) begin
        mPulses  = 0;
        decayNow = 1'b1;
      end
    end
    if (latch) begin
      for (int k = 0; k < NBINS; k++) begin
        lvl       = refLevel(int'(bus.i_fft_data[k*DW +: DW]));
        mLevel[k] = lvl;
        if (lvl > mPeak[k]) mPeak[k] = lvl;
      end
      mFrames = (mFrames + 1) % 65536;
      mPend   = 1'b0;
    end else begin
      if (bus.i_fft_done) mPend = 1'b1;
      if (decayNow) begin
        for (int k = 0; k < NBINS; k++) begin
          if (mPeak[k] > mLevel[k]) mPeak[k]--;
        end
      end
    end
  endtask

  // Colour the model expects for a pixel, computed from the stored levels and peaks
  function automatic logic [31:0] modelPixel(input int x, input int y, input int mode);
    int k, col, dy, lvl, pk;
    bit bar, peakHit;
    if (mode == 3 || x < X0 || y > Y_BASE) return BLACK;
    k   = (x - X0) / BAR_W;
    col = (x - X0) % BAR_W;
    if (k >= NBINS || col >= BAR_W - 2) return BLACK;
    dy      = Y_BASE - y;
    lvl     = mLevel[k];
    pk      = mPeak[k];
    bar     = dy < lvl * STEP_H;
    peakHit = (pk != 0) && (dy == pk * STEP_H);
    if (mode == 2 && peakHit) return WHITE;
    if (!bar) return BLACK;
    if (mode == 1) return {8'h00, 8'(lvl * 16), 8'(255 - lvl * 16), 8'd64};
    return GREEN;
  endfunction

  // One clock with the current inputs; the model follows while out of reset
  task automatic applyStimulus();
    if (rst_n) modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic setBin(input int k, input int v);
    bus.i_fft_data[k*DW +: DW] = DW'(v);
  endtask

  task automatic clearBins();
    bus.i_fft_data = '0;
  endtask

  task automatic pulseDone();
    bus.i_fft_done = 1'b1;
    applyStimulus();
    bus.i_fft_done = 1'b0;
  endtask

  task automatic pulseFrame();
    bus.i_frame_start = 1'b1;
    applyStimulus();
    bus.i_frame_start = 1'b0;
    applyStimulus();
  endtask

  // Request a latch and let it happen in blanking, then return to active video
  task automatic latchNow();
    bus.i_vga_lock = 1'b0;
    pulseDone();
    applyStimulus();
    bus.i_vga_lock = 1'b1;
  endtask

  // Present a pixel, wait out the two pipeline stages and compare the colour
  task automatic checkPixel(input string tag, input int x, input int y, input int mode,
                            input logic [31:0] expected);
    bus.i_vga_x = 11'(x);
    bus.i_vga_y = 11'(y);
    bus.i_mode  = 2'(mode);
    applyStimulus();
    applyStimulus();
    checkOutput(tag, rgbNow(), expected);
  endtask

  initial begin
    int x, y, mode, k;
    checkCount = 0;
    errorCount = 0;
    modelReset();
    rst_n             = 1'b0;
    bus.i_fft_data    = '0;
    bus.i_fft_done    = 1'b0;
    bus.i_vga_lock    = 1'b1;
    bus.i_frame_start = 1'b0;
    bus.i_vga_x       = '0;
    bus.i_vga_y       = '0;
    bus.i_mode        = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_rgb", rgbNow(), BLACK);
    checkOutput("rst_frame_cnt", 32'(bus.o_frame_cnt), 32'd0);
    rst_n = 1'b1;
    applyStimulus();

    // Blank screen after reset
    for (int i = 0; i < 6; i++) begin
      checkPixel("t1_sweep", X0 + i * 37, Y_BASE - i * 50, 0, BLACK);
    end
    checkOutput("t1_frame_cnt", 32'(bus.o_frame_cnt), 32'd0);

    // Latch is held off during active video and fires on the first blanking edge
    clearBins();
    setBin(0, 16'h8000);
    pulseDone();
    repeat (10) applyStimulus();
    checkOutput("t2_held_locked", 32'(bus.o_frame_cnt), 32'd0);
    bus.i_vga_lock = 1'b0;
    applyStimulus();
    checkOutput("t2_latch_edge", 32'(bus.o_frame_cnt), 32'd1);
    bus.i_vga_lock = 1'b1;
    checkPixel("t2_bar_bottom", 64, 440, 0, GREEN);
    checkPixel("t2_bar_above_top", 64, 80, 0, BLACK);
    checkPixel("t2_gap_column", 94, 440, 0, BLACK);
    checkPixel("t2_gradient", 64, 300, 1, 32'hF00F40);

    // Two results during one active period: one latch, newest data wins
    setBin(0, 16'h0100);
    pulseDone();
    repeat (3) applyStimulus();
    setBin(0, 16'h0010);
    pulseDone();
    repeat (3) applyStimulus();
    checkOutput("t3_still_pending", 32'(bus.o_frame_cnt), 32'd1);
    bus.i_vga_lock = 1'b0;
    applyStimulus();
    repeat (4) applyStimulus();
    checkOutput("t3_single_latch", 32'(bus.o_frame_cnt), 32'd2);
    bus.i_vga_lock = 1'b1;
    checkPixel("t3_level4_top", 64, 345, 0, GREEN);
    checkPixel("t3_level4_above", 64, 344, 0, BLACK);

    // Peak hold and decay on bin 3
    clearBins();
    setBin(3, 16'h0100);
    latchNow();
    setBin(3, 16'h0004);
    latchNow();
    checkOutput("t4_frame_cnt", 32'(bus.o_frame_cnt), 32'd4);
    checkPixel("t4_peak8", 160, 248, 2, WHITE);
    checkPixel("t4_empty_row", 160, 272, 2, BLACK);
    repeat (4) pulseFrame();
    checkPixel("t4_peak7", 160, 272, 2, WHITE);
    checkPixel("t4_old_peak_gone", 160, 248, 2, BLACK);
    repeat (20) pulseFrame();
    checkPixel("t4_peak2", 160, 392, 2, WHITE);
    repeat (8) pulseFrame();
    checkPixel("t4_peak_floor", 160, 392, 2, WHITE);
    checkPixel("t4_bar_under_peak", 160, 416, 2, GREEN);

    // Pipeline latency and level boundaries
    checkPixel("t5_start_black", 0, 440, 0, BLACK);
    bus.i_vga_x = 11'd160;
    applyStimulus();
    checkOutput("t5_latency_1", rgbNow(), BLACK);
    applyStimulus();
    checkOutput("t5_latency_2", rgbNow(), GREEN);
    setBin(3, 1);
    latchNow();
    checkPixel("t5_value1_no_bar", 160, 440, 0, BLACK);
    setBin(3, 16'hFFFF);
    latchNow();
    checkPixel("t5_ffff_top", 160, 81, 0, GREEN);
    checkPixel("t5_ffff_above", 160, 80, 0, BLACK);

    // Reset in the middle of a pending latch and an active frame
    setBin(3, 16'h0100);
    pulseDone();
    checkPixel("t6_before_reset", 160, 440, 0, GREEN);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("t6_rgb_async", rgbNow(), BLACK);
    checkOutput("t6_cnt_async", 32'(bus.o_frame_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.i_vga_lock = 1'b0;
    repeat (5) applyStimulus();
    checkOutput("t6_no_latch_after", 32'(bus.o_frame_cnt), 32'd0);
    bus.i_vga_lock = 1'b1;
    checkPixel("t6_levels_cleared", 160, 440, 0, BLACK);

    // Randomized frames with random blanking, frame pulses and pixel probes
    for (int it = 0; it < 40; it++) begin
      for (int b = 0; b < NBINS; b++) setBin(b, $urandom_range(0, 65535) >> $urandom_range(0, 16));
      bus.i_vga_lock = 1'($urandom_range(0, 1));
      pulseDone();
      for (int c = 0; c < 8; c++) begin
        if ($urandom_range(0, 3) == 0) setBin($urandom_range(0, NBINS - 1), $urandom_range(0, 65535));
        if ($urandom_range(0, 5) == 0) bus.i_fft_done = 1'b1;
        bus.i_vga_lock    = 1'($urandom_range(0, 1));
        bus.i_frame_start = ($urandom_range(0, 2) == 0);
        applyStimulus();
        bus.i_fft_done = 1'b0;
      end
      bus.i_frame_start = 1'b0;
      bus.i_vga_lock    = 1'b1;
      applyStimulus();
      checkOutput("rnd_frame_cnt", 32'(bus.o_frame_cnt), 32'(mFrames));
      for (int p = 0; p < 4; p++) begin
        k    = $urandom_range(0, NBINS);
        x    = X0 + k * BAR_W + $urandom_range(0, BAR_W - 1) - (($urandom_range(0, 7) == 0) ? 8 : 0);
        mode = $urandom_range(0, 3);
        if (k < NBINS && $urandom_range(0, 2) == 0) y = Y_BASE - mPeak[k] * STEP_H;
        else y = Y_BASE + 4 - $urandom_range(0, 390);
        checkPixel("rnd_pixel", x, y, mode, modelPixel(x, y, mode));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
